// File: rtl/uart_xor_block.sv
// ---------------------------------------------------------------------------
// uart_xor_block
//
// Receives an 8-byte block on an 8N1 UART line, XORs every byte with the key
// byte for its position in the block, and sends the 8 results back on the TX
// line in arrival order, as back-to-back 8N1 frames.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (12 MHz / 115200 = 104)
//   KEY           XOR key; block position i uses KEY[8i+7:8i]
//
// Ports
//   G_HPBX0000                   in   system clock, 12 MHz
//   MIB_R0C60_PIOT0_JPADDIA_PIO  in   asynchronous active-low reset pad
//   MIB_R0C40_PIOT0_JPADDIB_PIO  in   UART RX serial in, idle high
//   MIB_R0C40_PIOT0_PADDOA_PIO   out  UART TX serial out, idle high
//
// Block flow
//   RX FSM  -> one-cycle rx_valid pulse with rx_byte on a good stop bit
//   buffer  -> stores rx_byte ^ key byte at wr_idx; the 8th byte sets full
//   TX FSM  -> while full, streams entries 0..7; the last stop bit clears full
//   While full is set, newly received bytes are dropped, so a block cannot be
//   overwritten while it is being transmitted.
// ---------------------------------------------------------------------------
module uart_xor_block #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter logic [63:0] KEY          = 64'h8877665544332211
) (
   input  logic G_HPBX0000,
   input  logic MIB_R0C60_PIOT0_JPADDIA_PIO,
   input  logic MIB_R0C40_PIOT0_JPADDIB_PIO,
   output logic MIB_R0C40_PIOT0_PADDOA_PIO
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

   // Terminal counts: a counter that starts at 0 reaches these after exactly
   // HALF_BIT / CLKS_PER_BIT clocks.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   logic clk;
   logic rst_pad_n;
   logic rx_pad;

   assign clk       = G_HPBX0000;
   assign rst_pad_n = MIB_R0C60_PIOT0_JPADDIA_PIO;
   assign rx_pad    = MIB_R0C40_PIOT0_JPADDIB_PIO;

   // ------------------------------------------------------------------------
   // Reset synchronizer: assertion reaches every flop asynchronously (so TX
   // is forced high at once), release is aligned to clk by two flops.
   // ------------------------------------------------------------------------
   logic [1:0] rst_sync;
   logic       rst_n;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_pad_n) begin
      if (!rst_pad_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // ------------------------------------------------------------------------
   // RX input synchronizer (resets to the idle-high line level)
   // ------------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_pad;
         rx_s    <= rx_meta;
      end
   end

   // ------------------------------------------------------------------------
   // RX FSM: detects the falling start edge, re-checks it mid-bit, then
   // samples data and stop bits every CLKS_PER_BIT clocks from that point.
   // ------------------------------------------------------------------------
   rx_state_t        rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             rx_valid;
   logic [7:0]       rx_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (!rx_s) begin
                  rx_state <= RX_START;
               end
            end

            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  // A line already back high at mid start bit was a glitch.
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  // LSB arrives first, so shift in from the top.
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  // A low stop bit is a framing error: the byte is dropped.
                  rx_valid <= rx_s;
                  rx_byte  <= rx_shift;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            default: begin
               rx_state <= RX_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Block buffer
   // ------------------------------------------------------------------------
   logic [7:0] blk_mem [8];
   logic [2:0] wr_idx;
   logic       full;
   logic [7:0] key_byte;
   logic       rx_accept;
   logic       tx_last;

   // NOTE: combinational signals get a value on every path through the block,
   // so no latch is inferred.
   always_comb begin
      key_byte = KEY[{wr_idx, 3'b000} +: 8];
   end

   assign rx_accept = rx_valid && !full;

   // NOTE: the buffer array has no reset; an entry is always written before
   // it is read, and leaving it out keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (rx_accept) begin
         blk_mem[wr_idx] <= rx_byte ^ key_byte;
      end
   end

   // The index wraps 7 -> 0 on the same edge that full is set; full stays up
   // until the final stop bit of the response ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         full   <= 1'b0;
      end else if (tx_last) begin
         wr_idx <= '0;
         full   <= 1'b0;
      end else if (rx_accept) begin
         wr_idx <= wr_idx + 3'd1;
         if (wr_idx == 3'd7) begin
            full <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // TX sequencer: tx_line is registered and changes only at bit boundaries,
   // so every bit is held exactly CLKS_PER_BIT clocks.
   // ------------------------------------------------------------------------
   tx_state_t        tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;
   logic [2:0]       rd_idx;
   logic [2:0]       rd_next;
   logic             tx_line;

   assign rd_next = rd_idx + 3'd1;

   // Last clock of the 8th stop bit: the block is finished.
   assign tx_last = (tx_state == TX_STOP) && (tx_cnt == BIT_LAST) && (rd_idx == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         rd_idx   <= '0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_line <= 1'b1;
               tx_cnt  <= '0;
               rd_idx  <= '0;
               if (full) begin
                  tx_shift <= blk_mem[3'd0];
                  tx_line  <= 1'b0;
                  tx_state <= TX_START;
               end
            end

            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_line  <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     // tx_shift[0] is on the line; bit 1 goes next.
                     tx_bit   <= tx_bit + 3'd1;
                     tx_line  <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (rd_idx == 3'd7) begin
                     rd_idx   <= '0;
                     tx_state <= TX_IDLE;
                  end else begin
                     // Next start bit follows the stop bit with no gap.
                     rd_idx   <= rd_next;
                     tx_shift <= blk_mem[rd_next];
                     tx_line  <= 1'b0;
                     tx_state <= TX_START;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            default: begin
               tx_state <= TX_IDLE;
               tx_line  <= 1'b1;
            end
         endcase
      end
   end

   assign MIB_R0C40_PIOT0_PADDOA_PIO = tx_line;

endmodule

// File: tb/tb_uart_xor_block.sv
// ---------------------------------------------------------------------------
// tb_uart_xor_block
//
// Directed bench for uart_xor_block. A table of 8-byte blocks with their
// hand-computed responses is sent and compared, followed by hand-written
// sequences for glitch rejection, back-to-back blocks, framing error,
// reset mid-block and reset mid-response.
//
// The DUT divisor is shortened to 26 clocks per bit so the run stays short;
// every timing expectation (frame spacing, latency, glitch length) is
// derived from CPB, so the checks scale unchanged to the 104 default.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_xor_block;

   localparam int CPB    = 26;
   localparam int HALF   = CPB / 2;
   localparam int GLITCH = 8;         // shorter than HALF: must be rejected
   localparam int FRAME  = 10 * CPB;

   logic clk    = 1'b0;
   logic rst_pad = 1'b1;
   logic rx     = 1'b1;
   logic tx;

   uart_xor_block #(
      .CLKS_PER_BIT(CPB),
      .KEY         (64'h8877665544332211)
   ) dut (
      .G_HPBX0000                 (clk),
      .MIB_R0C60_PIOT0_JPADDIA_PIO(rst_pad),
      .MIB_R0C40_PIOT0_JPADDIB_PIO(rx),
      .MIB_R0C40_PIOT0_PADDOA_PIO (tx)
   );

   always #41.667 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;
   int last_stop_cyc = 0;

   // Quiet-window watcher: TX must not leave idle while quiet is set.
   logic quiet = 1'b0;
   int   quiet_viol = 0;
   always @(negedge clk) if (quiet && tx !== 1'b1) quiet_viol <= quiet_viol + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- TX monitor: decodes frames into a queue ----------------
   typedef struct {
      logic [7:0] data;
      logic       start;
      logic       stop;
      int         t;
   } frame_t;

   frame_t rxq[$];

   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            f.t = cyc;
            repeat (HALF) @(negedge clk);
            f.start = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               f.data[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            f.stop = tx;
            rxq.push_back(f);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int idle_bits);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      last_stop_cyc = cyc;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (idle_bits * CPB) @(negedge clk);
   endtask

   task automatic send_block(input logic [63:0] din, input int idle_bits);
      for (int i = 0; i < 8; i++) send_frame(din[8*i +: 8], 1'b1, idle_bits);
   endtask

   // Waits (bounded) for 8 frames and compares bytes, framing, spacing and
   // the response latency from the 8th byte's stop bit.
   task automatic expect_block(input string name, input logic [63:0] exp);
      int waited = 0;
      int n;
      int lat;
      while (rxq.size() < 8 && waited < 100 * CPB) begin
         @(negedge clk);
         waited++;
      end
      check({name, " frames"}, 64'(rxq.size()), 64'd8);
      n = (rxq.size() < 8) ? rxq.size() : 8;
      if (n > 0) begin
         lat = rxq[0].t - last_stop_cyc;
         check({name, " latency"}, 64'((lat >= HALF) && (lat <= HALF + 7)), 64'd1);
      end
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s byte%0d", name, i),
               64'({rxq[i].stop, rxq[i].data, rxq[i].start}),
               64'({1'b1, exp[8*i +: 8], 1'b0}));
         if (i > 0) check($sformatf("%s spacing%0d", name, i),
                          64'(rxq[i].t - rxq[i-1].t), 64'(FRAME));
      end
      repeat (n) void'(rxq.pop_front());
      // Let the last stop bit finish, then the line must be idle and quiet.
      repeat (2 * CPB) @(negedge clk);
      check({name, " idle"}, 64'({rxq.size() != 0, tx}), 64'b01);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic [63:0] din;
      logic [63:0] dout;
      int          idle;
   } vec_t;

   vec_t vecs[3];

   initial begin
      #(20ms);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"basic",   64'h0706050403020100, 64'h8F71635147312311, 1};
      vecs[1] = '{"ones",    64'hFFFFFFFFFFFFFFFF, 64'h778899AABBCCDDEE, 0};
      vecs[2] = '{"pattern", 64'hF0E1D2C3B4A59687, 64'h7896B496F096B496, 0};

      // Reset: TX high during and after reset.
      #1 rst_pad = 1'b0;
      repeat (5) @(negedge clk);
      check("reset tx during", 64'(tx), 64'd1);
      rst_pad = 1'b1;
      repeat (5) @(negedge clk);
      check("reset tx after", 64'(tx), 64'd1);
      check("reset no frames", 64'(rxq.size()), 64'd0);

      for (int v = 0; v < 3; v++) begin
         send_block(vecs[v].din, vecs[v].idle);
         expect_block(vecs[v].name, vecs[v].dout);
      end

      // Glitch shorter than half a bit, then a block of zeros.
      rx = 1'b0;
      repeat (GLITCH) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send_block(64'h0, 0);
      expect_block("glitch", 64'h8877665544332211);

      // Second zeros block straight after: TX must stay high until it is due.
      quiet = 1'b1;
      for (int i = 0; i < 7; i++) send_frame(8'h00, 1'b1, 0);
      quiet = 1'b0;
      send_frame(8'h00, 1'b1, 0);
      check("b2b quiet", 64'(quiet_viol), 64'd0);
      expect_block("b2b", 64'h8877665544332211);

      // Framing error: bad byte is dropped and does not count.
      for (int i = 0; i < 4; i++) send_frame(8'(i), 1'b1, 1);
      send_frame(8'h5A, 1'b0, 1);
      for (int i = 0; i < 3; i++) send_frame(8'h00, 1'b1, 1);
      repeat (CPB) @(negedge clk);
      check("framing early", 64'(rxq.size()), 64'd0);
      send_frame(8'h00, 1'b1, 1);
      expect_block("framing", 64'h8877665547312311);

      // Reset mid-block: partial block is lost.
      for (int i = 0; i < 4; i++) send_frame(8'hAA, 1'b1, 1);
      rst_pad = 1'b0;
      #(10us);
      check("rst_mid tx", 64'(tx), 64'd1);
      @(negedge clk);
      rst_pad = 1'b1;
      repeat (4) @(negedge clk);
      send_block(64'h0706050403020100, 1);
      expect_block("rst_mid", 64'h8F71635147312311);

      // Reset mid-response: TX forced high immediately, no resumption.
      begin
         int waited = 0;
         send_block(64'h0, 0);
         while (tx !== 1'b0 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
         end
         check("rst_tx started", 64'(tx), 64'd0);
         repeat (3 * CPB) @(negedge clk);
         rst_pad = 1'b0;
         #1;
         check("rst_tx forced high", 64'(tx), 64'd1);
         repeat (5) @(negedge clk);
         rst_pad = 1'b1;
         repeat (12 * CPB) @(negedge clk);
         rxq.delete();
         repeat (12 * CPB) @(negedge clk);
         check("rst_tx no resume", 64'({rxq.size() != 0, tx}), 64'b01);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
